// File: rtl/mole_target_ctrl.sv
// mole_target_ctrl: requests a random word, lights one target, times on/gap windows and tallies hits and misses
module mole_target_ctrl #(
  parameter int N_TGT   = 8,
  parameter int RND_W   = 5,
  parameter int ON_CYC  = 50,
  parameter int GAP_CYC = 10,
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [RND_W-1:0]   rnd,
  output logic               rnd_en,
  input  logic [N_TGT-1:0]   hit,
  output logic [N_TGT-1:0]   tgt,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] miss,
  output logic               busy
);
  localparam int IW   = (N_TGT > 1) ? $clog2(N_TGT) : 1;
  localparam int TMAX = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [SCORE_W-1:0] SMAX = '1;
  localparam logic [N_TGT-1:0]   ONE  = N_TGT'(1);
  typedef enum logic [2:0] {IDLE, REQ, PICK, SHOW, GAP} state_e;
  state_e             state_q;
  logic [N_TGT-1:0]   tgt_q;
  logic [SCORE_W-1:0] score_q, miss_q, score_d, miss_d;
  logic [TW-1:0]      timer_q;
  logic [IW-1:0]      prev_q, idx_raw, idx_d;
  logic [1:0]         rej_q;
  logic               first_q, rnd_en_q, busy_q, rep, correct;
  always_comb begin
    idx_raw = IW'(32'(rnd) % N_TGT);
    rep     = !first_q && (idx_raw == prev_q);
    idx_d   = rep ? prev_q + 1'b1 : idx_raw;
    correct = |(hit & tgt_q);
    score_d = (score_q == SMAX) ? score_q : score_q + 1'b1;
    miss_d  = (miss_q == SMAX) ? miss_q : miss_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tgt_q    <= '0;
      score_q  <= '0;
      miss_q   <= '0;
      rnd_en_q <= 1'b0;
      busy_q   <= 1'b0;
      timer_q  <= '0;
      prev_q   <= '0;
      first_q  <= 1'b1;
      rej_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q  <= REQ;
          rnd_en_q <= 1'b1;
          busy_q   <= 1'b1;
          score_q  <= '0;
          miss_q   <= '0;
          first_q  <= 1'b1;
          rej_q    <= '0;
        end
        REQ: begin
          state_q  <= PICK;
          rnd_en_q <= 1'b0;
        end
        PICK: if (rep && rej_q != 2'd3) begin
          rej_q    <= rej_q + 1'b1;
          state_q  <= REQ;
          rnd_en_q <= 1'b1;
        end else begin
          // after three repeats the neighbour is forced so a stuck generator cannot stall the game
          tgt_q   <= ONE << idx_d;
          prev_q  <= idx_d;
          first_q <= 1'b0;
          rej_q   <= '0;
          timer_q <= TW'(ON_CYC - 1);
          state_q <= SHOW;
        end
        SHOW: if (correct) begin
          score_q <= score_d;
          tgt_q   <= '0;
          timer_q <= TW'(GAP_CYC - 1);
          state_q <= GAP;
        end else if (timer_q == '0) begin
          miss_q  <= miss_d;
          tgt_q   <= '0;
          timer_q <= TW'(GAP_CYC - 1);
          state_q <= GAP;
        end else begin
          timer_q <= timer_q - 1'b1;
          if (|hit) miss_q <= miss_d;
        end
        GAP: if (timer_q != '0) begin
          timer_q <= timer_q - 1'b1;
        end else if (start) begin
          state_q  <= REQ;
          rnd_en_q <= 1'b1;
        end else begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rnd_en = rnd_en_q;
  assign tgt    = tgt_q;
  assign score  = score_q;
  assign miss   = miss_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_mole_target_ctrl.sv
// tb_mole_target_ctrl: directed scenarios plus randomized rounds checked against a round-level game model
module tb_mole_target_ctrl;
  localparam int N_TGT = 8, RND_W = 5, ON_CYC = 4, GAP_CYC = 2, SCORE_W = 2;
  localparam int SMAX = (1 << SCORE_W) - 1;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, rnd_en, busy;
  logic [RND_W-1:0] rnd = '0;
  logic [N_TGT-1:0] hit = '0, tgt;
  logic [N_TGT-1:0] one = N_TGT'(1);
  logic [SCORE_W-1:0] score, miss;
  int n_chk = 0, n_fail = 0;
  int m_prev, m_first, m_score, m_miss;

  mole_target_ctrl #(.N_TGT(N_TGT), .RND_W(RND_W), .ON_CYC(ON_CYC), .GAP_CYC(GAP_CYC), .SCORE_W(SCORE_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rnd(rnd), .rnd_en(rnd_en),
    .hit(hit), .tgt(tgt), .score(score), .miss(miss), .busy(busy));

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; hit = '0;
    tick; tick;
    rst = 1'b0;
    m_prev = 0; m_first = 1; m_score = 0; m_miss = 0;
  endtask

  task automatic wait_req(output int cyc);
    cyc = 0;
    while (rnd_en !== 1'b1 && cyc < 50) begin tick; cyc++; end
  endtask

  task automatic test_reset;
    do_reset;
    n_chk++; if ({tgt, score, miss, rnd_en, busy} !== '0) begin n_fail++;
      $display("FAIL reset_state: got tgt=%h score=%0d miss=%0d rnd_en=%b busy=%b, want all 0", tgt, score, miss, rnd_en, busy); end
    tick; tick;
    n_chk++; if (busy !== 1'b0 || rnd_en !== 1'b0) begin n_fail++;
      $display("FAIL reset_idle_hold: got busy=%b rnd_en=%b, want 0 0", busy, rnd_en); end
  endtask

  task automatic test_basic_round;
    do_reset;
    start = 1'b1; tick;
    n_chk++; if (rnd_en !== 1'b1 || busy !== 1'b1) begin n_fail++;
      $display("FAIL basic_req: got rnd_en=%b busy=%b, want 1 1", rnd_en, busy); end
    rnd = 5'b10110; tick;
    n_chk++; if (rnd_en !== 1'b0 || tgt !== '0) begin n_fail++;
      $display("FAIL basic_pick: got rnd_en=%b tgt=%h, want 0 00", rnd_en, tgt); end
    tick;
    for (int c = 0; c < ON_CYC; c++) begin
      n_chk++; if (tgt !== 8'b0100_0000) begin n_fail++;
        $display("FAIL basic_lit c%0d: got tgt=%h, want 40", c, tgt); end
      tick;
    end
    for (int c = 0; c < GAP_CYC; c++) begin
      n_chk++; if (tgt !== '0 || rnd_en !== 1'b0 || miss !== 2'd1) begin n_fail++;
        $display("FAIL basic_gap c%0d: got tgt=%h rnd_en=%b miss=%0d, want 00 0 1", c, tgt, rnd_en, miss); end
      tick;
    end
    n_chk++; if (rnd_en !== 1'b1) begin n_fail++;
      $display("FAIL basic_next_req: got rnd_en=%b, want 1", rnd_en); end
  endtask

  task automatic test_correct_hit;
    int cyc;
    do_reset;
    start = 1'b1; wait_req(cyc);
    rnd = 5'd3; tick; tick;
    n_chk++; if (tgt !== 8'h08 || cyc >= 50) begin n_fail++;
      $display("FAIL hit_lit: got tgt=%h wait=%0d, want 08 <50", tgt, cyc); end
    tick; hit = 8'h08; tick; hit = '0;
    n_chk++; if (tgt !== '0 || score !== 2'd1 || miss !== 2'd0 || busy !== 1'b1) begin n_fail++;
      $display("FAIL hit_result: got tgt=%h score=%0d miss=%0d busy=%b, want 00 1 0 1", tgt, score, miss, busy); end
    tick;
    n_chk++; if (rnd_en !== 1'b0) begin n_fail++;
      $display("FAIL hit_gap: got rnd_en=%b, want 0", rnd_en); end
    tick;
    n_chk++; if (rnd_en !== 1'b1) begin n_fail++;
      $display("FAIL hit_gap_end: got rnd_en=%b, want 1", rnd_en); end
  endtask

  task automatic test_wrong_then_both;
    int cyc;
    do_reset;
    start = 1'b1; wait_req(cyc);
    rnd = 5'd3; tick; tick;
    hit = 8'h01; tick; hit = '0;
    n_chk++; if (miss !== 2'd1 || score !== 2'd0 || tgt !== 8'h08) begin n_fail++;
      $display("FAIL wrong_press: got miss=%0d score=%0d tgt=%h, want 1 0 08", miss, score, tgt); end
    hit = 8'h09; tick; hit = '0;
    n_chk++; if (score !== 2'd1 || miss !== 2'd1 || tgt !== '0) begin n_fail++;
      $display("FAIL both_press: got score=%0d miss=%0d tgt=%h, want 1 1 00", score, miss, tgt); end
  endtask

  task automatic test_repeat_reject;
    int cyc, pulses;
    do_reset;
    start = 1'b1; wait_req(cyc);
    rnd = 5'b00010; tick; tick;
    n_chk++; if (tgt !== 8'h04) begin n_fail++;
      $display("FAIL rej_first: got tgt=%h, want 04", tgt); end
    hit = 8'h04; tick; hit = '0;
    wait_req(cyc);
    pulses = 0; cyc = 0;
    while (tgt === '0 && cyc < 40) begin
      if (rnd_en === 1'b1) pulses++;
      tick; cyc++;
    end
    n_chk++; if (pulses != 4 || cyc != 8) begin n_fail++;
      $display("FAIL rej_pulses: got pulses=%0d cycles=%0d, want 4 8", pulses, cyc); end
    n_chk++; if (tgt !== 8'h08) begin n_fail++;
      $display("FAIL rej_forced: got tgt=%h, want 08", tgt); end
  endtask

  task automatic test_saturation;
    int cyc;
    int seq[5] = '{1, 2, 3, 3, 3};
    do_reset;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_req(cyc);
      rnd = RND_W'(i); tick; tick;
      n_chk++; if (tgt !== (one << i) || cyc >= 50) begin n_fail++;
        $display("FAIL sat_lit r%0d: got tgt=%h wait=%0d, want %h <50", i, tgt, cyc, one << i); end
      hit = one << i; tick; hit = '0;
      n_chk++; if (score !== SCORE_W'(seq[i])) begin n_fail++;
        $display("FAIL sat_score r%0d: got %0d, want %0d", i, score, seq[i]); end
    end
  endtask

  task automatic test_stop_reset;
    int cyc, lit;
    do_reset;
    start = 1'b1; wait_req(cyc);
    rnd = 5'd5; tick; tick;
    hit = 8'h20; tick; hit = '0;
    wait_req(cyc);
    rnd = 5'd7; tick; tick;
    n_chk++; if (tgt !== 8'h80) begin n_fail++;
      $display("FAIL stop_lit: got tgt=%h, want 80", tgt); end
    start = 1'b0; lit = 0;
    while (tgt !== '0 && lit < 20) begin lit++; tick; end
    n_chk++; if (lit != ON_CYC) begin n_fail++;
      $display("FAIL stop_lit_len: got %0d, want %0d", lit, ON_CYC); end
    tick;
    n_chk++; if (busy !== 1'b1) begin n_fail++;
      $display("FAIL stop_gap_busy: got %b, want 1", busy); end
    tick;
    n_chk++; if (busy !== 1'b0 || rnd_en !== 1'b0 || score !== 2'd1 || miss !== 2'd1) begin n_fail++;
      $display("FAIL stop_idle: got busy=%b rnd_en=%b score=%0d miss=%0d, want 0 0 1 1", busy, rnd_en, score, miss); end
    tick; tick; tick;
    n_chk++; if (busy !== 1'b0 || score !== 2'd1 || miss !== 2'd1) begin n_fail++;
      $display("FAIL stop_hold: got busy=%b score=%0d miss=%0d, want 0 1 1", busy, score, miss); end
    start = 1'b1; tick;
    n_chk++; if (rnd_en !== 1'b1 || busy !== 1'b1 || score !== '0 || miss !== '0) begin n_fail++;
      $display("FAIL restart_clear: got rnd_en=%b busy=%b score=%0d miss=%0d, want 1 1 0 0", rnd_en, busy, score, miss); end
    rnd = 5'd1; tick; tick;
    hit = 8'h02; tick; hit = '0;
    wait_req(cyc);
    rnd = 5'd4; tick; tick; tick;
    n_chk++; if (tgt !== 8'h10 || score !== 2'd1) begin n_fail++;
      $display("FAIL rst_pre: got tgt=%h score=%0d, want 10 1", tgt, score); end
    rst = 1'b1; start = 1'b0; tick;
    n_chk++; if (tgt !== '0 || score !== '0 || miss !== '0 || busy !== 1'b0 || rnd_en !== 1'b0) begin n_fail++;
      $display("FAIL rst_mid_show: got tgt=%h score=%0d miss=%0d busy=%b rnd_en=%b, want all 0", tgt, score, miss, busy, rnd_en); end
    rst = 1'b0;
  endtask

  task automatic test_random;
    logic [RND_W-1:0] rs[4];
    logic [N_TGT-1:0] hv[ON_CYC];
    logic [N_TGT-1:0] oh;
    int exp_idx, exp_pulses, exp_lit, pulses, cyc, act, hcyc, ip;
    bit stop;
    do_reset;
    start = 1'b1; tick;
    for (int r = 0; r < 60; r++) begin
      stop = (r % 5 == 4);
      for (int k = 0; k < 4; k++) begin
        ip = ($urandom_range(0, 1) == 1) ? m_prev : int'($urandom_range(0, N_TGT - 1));
        rs[k] = RND_W'((int'($urandom) & ~(N_TGT - 1)) | ip);
      end
      exp_pulses = 4; exp_idx = (m_prev + 1) % N_TGT;
      for (int k = 0; k < 4; k++)
        if (m_first != 0 || int'(rs[k]) % N_TGT != m_prev) begin
          exp_idx = int'(rs[k]) % N_TGT; exp_pulses = k + 1; break;
        end
      m_prev = exp_idx; m_first = 0;
      oh = one << exp_idx;
      act = $urandom_range(0, 2); hcyc = $urandom_range(0, ON_CYC - 1);
      for (int c = 0; c < ON_CYC; c++) begin
        hv[c] = (act != 0 && $urandom_range(0, 2) == 0) ? (N_TGT'($urandom) & ~oh) : '0;
        if (act == 1 && c == hcyc) hv[c] = oh | (N_TGT'($urandom) & ~oh);
      end
      exp_lit = ON_CYC;
      for (int c = 0; c < ON_CYC; c++) begin
        if ((hv[c] & oh) != '0) begin
          m_score = (m_score < SMAX) ? m_score + 1 : SMAX; exp_lit = c + 1; break;
        end
        if (c == ON_CYC - 1 || hv[c] != '0) m_miss = (m_miss < SMAX) ? m_miss + 1 : SMAX;
      end
      pulses = 0; cyc = 0;
      while (tgt === '0 && cyc < 40) begin
        if (rnd_en === 1'b1) begin rnd = rs[pulses < 4 ? pulses : 3]; pulses++; end
        tick; cyc++;
      end
      n_chk++; if (pulses != exp_pulses || cyc != 2 * exp_pulses) begin n_fail++;
        $display("FAIL rnd_req r%0d: got pulses=%0d cycles=%0d, want %0d %0d", r, pulses, cyc, exp_pulses, 2 * exp_pulses); end
      for (int c = 0; c < exp_lit; c++) begin
        n_chk++; if (tgt !== oh) begin n_fail++;
          $display("FAIL rnd_tgt r%0d c%0d: got %h, want %h", r, c, tgt, oh); end
        hit = hv[c];
        if (stop && c == 0) start = 1'b0;
        tick; hit = '0;
      end
      n_chk++; if (tgt !== '0 || score !== SCORE_W'(m_score) || miss !== SCORE_W'(m_miss)) begin n_fail++;
        $display("FAIL rnd_result r%0d: got tgt=%h score=%0d miss=%0d, want 00 %0d %0d", r, tgt, score, miss, m_score, m_miss); end
      for (int g = 0; g < GAP_CYC; g++) begin
        n_chk++; if (tgt !== '0 || rnd_en !== 1'b0 || busy !== 1'b1) begin n_fail++;
          $display("FAIL rnd_gap r%0d g%0d: got tgt=%h rnd_en=%b busy=%b, want 00 0 1", r, g, tgt, rnd_en, busy); end
        tick;
      end
      if (stop) begin
        n_chk++; if (busy !== 1'b0 || rnd_en !== 1'b0) begin n_fail++;
          $display("FAIL rnd_stop r%0d: got busy=%b rnd_en=%b, want 0 0", r, busy, rnd_en); end
        start = 1'b1; tick;
        m_first = 1; m_score = 0; m_miss = 0;
      end
      n_chk++; if (rnd_en !== 1'b1) begin n_fail++;
        $display("FAIL rnd_next_req r%0d: got rnd_en=%b, want 1", r, rnd_en); end
    end
    start = 1'b0; cyc = 0;
    while (busy !== 1'b0 && cyc < 60) begin tick; cyc++; end
    n_chk++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL rnd_final_idle: got busy=%b, want 0", busy); end
  endtask

  initial begin
    test_reset;
    test_basic_round;
    test_correct_hit;
    test_wrong_then_both;
    test_repeat_reject;
    test_saturation;
    test_stop_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mole_target_ctrl.md
Name: mole_target_ctrl

Overview:
- Game-control stage directly downstream of rand_gen, and its only user.
- Pulses rand_gen's enable, samples the 5-bit random word, and turns it into one lit target out of N_TGT.
- Times each target's on-window and the gap after it, scores correct hits, and counts misses.
- Outputs drive the LED/target bank and feed score/miss values to the text-LCD display stage.

Parameters:
- N_TGT, 8, number of targets; power of two, 2..32.
- RND_W, 5, width of the rand_gen output.
- ON_CYC, 50, maximum cycles a target stays lit; must be >= 1.
- GAP_CYC, 10, dark cycles between targets; must be >= 1.
- SCORE_W, 8, width of the score and miss counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; 1 = game running.
- rnd  in  RND_W  random word from rand_gen; valid the cycle after rnd_en.
- rnd_en  out  1  enable to rand_gen.
- hit  in  N_TGT  one-cycle, already-debounced button pulses, one bit per target.
- tgt  out  N_TGT  one-hot lit target, or all zero.
- score  out  SCORE_W  correct-hit count.
- miss  out  SCORE_W  timeout count plus wrong-button count.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, tgt=0, score=0, miss=0, rnd_en=0, busy=0, timer=0, prev_idx=0, first=1, rej_cnt=0.
- rst wins over all other inputs in every state. An assertion mid-game returns to IDLE on the next edge.
- rnd_en is high exactly in the cycles the FSM is in REQ.
- idx = rnd[log2(N_TGT)-1:0].

FSM states:
- IDLE
  - tgt=0.
  - If start=1: go to REQ next cycle, clear score and miss, set first=1.
- REQ
  - rnd_en=1 for one cycle; go to PICK.
- PICK
  - Sample rnd.
  - Repeat case: first=0, idx==prev_idx, rej_cnt<3.
    - rej_cnt++, go back to REQ.
  - Forced accept: idx==prev_idx, rej_cnt==3.
    - Use idx=(prev_idx+1) mod N_TGT. This guards against a stuck generator.
  - On accept:
    - Load tgt=1<<idx and prev_idx=idx.
    - Clear first and rej_cnt.
    - Load timer=ON_CYC-1, go to SHOW.
  - tgt is visible from the first SHOW cycle.
- SHOW (tgt held)
  - Correct hit: hit & tgt != 0.
    - score++, saturating at 2^SCORE_W-1.
    - tgt=0 next cycle, go to GAP.
    - Takes priority over wrong bits in the same hit vector and over the timeout.
  - Wrong press: hit != 0 with only wrong bits.
    - miss++ (saturating), stay in SHOW.
    - Timer keeps running; each pulse cycle counts once, regardless of how many bits are set.
  - Timeout: timer==0 and no correct hit.
    - miss++ (once, even if a wrong press occurs in the same cycle), tgt=0, go to GAP.
  - Otherwise timer--.
  - Net effect: maximum lit time is exactly ON_CYC cycles.
- GAP (tgt=0)
  - Entry loads timer=GAP_CYC-1.
  - Timer decrements each cycle.
  - At 0: go to REQ if start=1, else IDLE.
  - hit is ignored in GAP.
- start is sampled only in IDLE and at the end of GAP. Dropping it mid-target lets the current target finish normally.
- score and miss hold their values in IDLE until the next game begins.
- Cycle latency, start rising edge to first lit target (no rejection): IDLE→REQ→PICK→SHOW = 3 cycles. Each rejection adds 2 cycles.

Test Plan:
- Basic round, with N_TGT=8, ON_CYC=4, GAP_CYC=2:
  - Stimulus: rst 2 cycles, start=1, rnd=5'b10110 after rnd_en, no hits.
  - Required: rnd_en high 1 cycle; tgt=8'b01000000 for exactly 4 cycles; miss=1; tgt=0 for 2 cycles; next rnd_en pulse follows.
- Correct hit:
  - Stimulus: target idx 3 lit; hit=8'h08 on the 2nd SHOW cycle.
  - Required: score=1, miss=0; tgt=0 on the next cycle; GAP starts.
- Wrong press then simultaneous press:
  - Stimulus: idx 3 lit; hit=8'h01 on cycle 1, then hit=8'h09 on cycle 2.
  - Required: miss=1 after cycle 1; score=1 after cycle 2; miss unchanged at 1.
- Repeat rejection:
  - Stimulus: previous idx=2; rnd returns 5'b00010 four times.
  - Required: three extra REQ pulses; then tgt=8'h08 (forced idx 3).
- Saturation, with SCORE_W=2:
  - Stimulus: five consecutive correct hits.
  - Required: score sequence 1,2,3,3,3.
- Stop and reset:
  - Stimulus: drop start during SHOW.
  - Required: target completes, GAP runs, then IDLE with busy=0 and score held.
  - Stimulus: start again.
  - Required: score and miss clear to 0.
  - Stimulus: rst mid-SHOW.
  - Required: tgt=0, score=0, IDLE on the next edge.
